// File: rtl/dec_scan_pkg.sv
// ============================================================================
// Package : dec_scan_pkg
// Purpose : Shared constants and helpers for the dec_scan decoder/scanner.
//           MODE_DIRECT / MODE_SCAN encode the mode input; calc_out_w derives
//           the one-hot output width from the index width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // One output line per representable index value.
  function automatic int calc_out_w(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_tick_gen.sv
// ============================================================================
// Module  : dec_tick_gen
// Purpose : Scan prescaler. Counts 0..div and asserts tick in the cycle the
//           count equals div, then restarts from 0.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           clr   - synchronous clear of the counter to 0
//           div   - tick period minus one, in clk cycles
//           tick  - high while the count equals div
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_tick_gen
  import dec_scan_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Equality compare: if div is lowered below the running count, the counter
  // keeps counting and rolls over at its natural width rather than ticking
  // early.
  assign tick = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dec_scan.sv
// ============================================================================
// Module  : dec_scan
// Purpose : Registered one-hot decoder with an optional auto-scan mode for
//           multiplexed displays.
//           mode=0 decodes in directly.
//           mode=1 steps idx from 0 up to in, one step per prescaler tick,
//           pulsing wrap when it returns to 0.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           en    - enable; 0 drives out inactive and holds idx
//           mode  - 0 direct decode, 1 auto-scan
//           in    - direct index / last index of the scan range
//           div   - scan tick period minus one
//           out   - registered one-hot decode of idx
//           idx   - registered current index
//           wrap  - one-cycle pulse on scan wrap to index 0
// Config  : DEC_SCAN_ACTIVE_LOW_EN - when defined, out is one-cold
//           (inactive = all ones) for common-anode drive.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_scan
  import dec_scan_pkg::*;
#(
  parameter  int IN_W  = 3,
  parameter  int DIV_W = 16,
  localparam int OUT_W = calc_out_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [IN_W-1:0]  in,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] out,
  output logic [IN_W-1:0]  idx,
  output logic             wrap
);

`ifdef DEC_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] OUT_IDLE = '0;
`endif

  logic             mode_q;
  logic [IN_W-1:0]  idx_q;
  logic [IN_W-1:0]  idx_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_d;
  logic             wrap_q;
  logic             wrap_d;

  logic             scan_active;
  logic             mode_switch;
  logic             tick_raw;
  logic             tick;
  logic [OUT_W-1:0] onehot;

  // mode_q resets to direct so the first scan edge after reset behaves as a
  // direct->scan switch: index 0 is shown for a full tick period.
  assign scan_active = en && (mode == MODE_SCAN);
  assign mode_switch = (mode != mode_q);

  dec_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scan_active || mode_switch),
    .div   (div),
    .tick  (tick_raw)
  );

  // A switch edge restarts the scan, so any coincident prescaler tick is
  // discarded.
  assign tick = scan_active && !mode_switch && tick_raw;

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        idx_d = in;
      end else if (mode_switch) begin
        idx_d = '0;
      end else if (tick) begin
        // >= rather than == so that lowering in below idx mid-scan still
        // wraps on the next tick.
        if (idx_q >= in) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IN_W'(1);
        end
      end
    end
  end

  // The decode of the next index is the only logic ahead of the out
  // register, so out always matches idx on the same edge.
  assign onehot = OUT_W'(1) << idx_d;

  always_comb begin
    out_d = OUT_IDLE;
    if (en) begin
`ifdef DEC_SCAN_ACTIVE_LOW_EN
      out_d = ~onehot;
`else
      out_d = onehot;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      idx_q  <= '0;
      out_q  <= OUT_IDLE;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode;
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_scan.sv
// ============================================================================
// Module  : tb_dec_scan
// Purpose : Directed self-checking bench for dec_scan (IN_W=3, DIV_W=16,
//           active-high outputs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [2:0]  in_s;
  logic [15:0] div_s;
  logic [7:0]  out_s;
  logic [2:0]  idx_s;
  logic        wrap_s;

  int n_tests = 0;
  int n_fail  = 0;

  dec_scan #(
    .IN_W  (3),
    .DIV_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in_s),
    .div   (div_s),
    .out   (out_s),
    .idx   (idx_s),
    .wrap  (wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [7:0] e_out,
                      input logic [2:0] e_idx, input logic e_wrap);
    chk({tag, ".out"},  {24'd0, out_s}, {24'd0, e_out});
    chk({tag, ".idx"},  {29'd0, idx_s}, {29'd0, e_idx});
    chk({tag, ".wrap"}, {31'd0, wrap_s}, {31'd0, e_wrap});
  endtask

  initial begin
    logic [2:0] e_idx;
    logic [7:0] e_out;
    logic       e_wrap;

    // ---------------- reset ----------------
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_s = 3'd0; div_s = 16'd0;
    step();
    step();
    chk3("reset", 8'h00, 3'd0, 1'b0);

    // ---------------- direct decode 0..7 ----------------
    rst_n = 1'b1; en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_s = 3'(i);
      step();
      e_out = 8'h01 << i;
      chk3($sformatf("direct%0d", i), e_out, 3'(i), 1'b0);
    end

    // ---------------- enable ----------------
    en = 1'b0; in_s = 3'd5;
    step();
    chk3("en_off", 8'h00, 3'd7, 1'b0);
    en = 1'b1;
    step();
    chk3("en_on", 8'h20, 3'd5, 1'b0);

    // ---------------- scan in=3 div=2 ----------------
    mode = 1'b1; in_s = 3'd3; div_s = 16'd2;
    for (int k = 0; k < 15; k++) begin
      step();
      e_idx  = 3'((k / 3) % 4);
      e_out  = 8'h01 << e_idx;
      e_wrap = (k == 12);
      chk3($sformatf("scan_k%0d", k), e_out, e_idx, e_wrap);
    end

    // ---------------- scan -> direct -> scan, div=0 ----------------
    mode = 1'b0; in_s = 3'd4;
    step();
    chk3("to_direct", 8'h10, 3'd4, 1'b0);
    mode = 1'b1; in_s = 3'd7; div_s = 16'd0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk3($sformatf("fast_k%0d", k), 8'h01 << k, 3'(k), 1'b0);
    end
    // idx is 6 now; shrink the range below it
    in_s = 3'd2;
    step();
    chk3("shrink_wrap", 8'h01, 3'd0, 1'b1);
    in_s = 3'd7;
    for (int j = 1; j <= 16; j++) begin
      step();
      e_idx = 3'(j % 8);
      chk3($sformatf("full_j%0d", j), 8'h01 << e_idx, e_idx, (j % 8) == 0);
    end

    // ---------------- reset mid-scan ----------------
    for (int j = 1; j <= 5; j++) step();
    chk3("pre_rst", 8'h20, 3'd5, 1'b0);
    div_s = 16'd2;
    #3;
    rst_n = 1'b0;
    #1;
    chk3("async_rst", 8'h00, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk3($sformatf("post_rst%0d", k), 8'h01, 3'd0, 1'b0);
    end
    step();
    chk3("post_rst_tick", 8'h02, 3'd1, 1'b0);

    // ---------------- scan -> direct ----------------
    mode = 1'b0; in_s = 3'd6;
    step();
    chk3("scan_to_direct", 8'h40, 3'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter IN_W, default 3, select/index width in bits (1..6).
REQ-002 Parameter DIV_W, default 16, scan prescaler width in bits.
REQ-003 Derived constant OUT_W = 2**IN_W, one-hot output width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  block enable; 0 forces all outputs inactive.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 in  input  IN_W  direct mode: index to decode; scan mode: last index of scan range.
REQ-009 div  input  DIV_W  scan mode: tick period minus one, in clk cycles.
REQ-010 out  output  OUT_W  registered one-hot decode of idx.
REQ-011 idx  output  IN_W  currently decoded index, registered.
REQ-012 wrap  output  1  one-cycle pulse when scan wraps to index 0.

Function
REQ-013 Direct mode, en=1: SHALL register idx <= in and out <= 1<<in; latency 1 cycle from in to out.
REQ-014 en=0: out SHALL be all-inactive on the next edge; idx held; prescaler cleared to 0; wrap 0.
REQ-015 Scan mode: prescaler cnt SHALL count 0..div; tick asserted in the cycle cnt==div, cnt then returns to 0.
REQ-016 div=0: tick SHALL occur every enabled cycle.
REQ-017 On tick, if idx >= in: idx <= 0 and wrap pulses 1 cycle; else idx <= idx+1.
REQ-018 in lowered below current idx mid-scan: next tick SHALL wrap to 0 (REQ-017), no out-of-range index held past that tick.
REQ-019 in = OUT_W-1: scan SHALL cover every index 0..OUT_W-1 without overflow.
REQ-020 out SHALL be updated on the same edge as idx, always one-hot of the new idx while en=1.
REQ-021 Direct->scan switch: on the first scan-mode edge idx <= 0, cnt <= 0, out <= one-hot(0), no wrap pulse.
REQ-022 Scan->direct switch: on the first direct-mode edge idx <= in, cnt <= 0, wrap 0.
REQ-023 Changes to div mid-count SHALL take effect at the next compare; if cnt > new div, cnt continues to wrap at its natural width (no glitch tick).
REQ-024 wrap SHALL never be asserted in direct mode or while en=0.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear idx, cnt, wrap to 0 and out to all-inactive.
REQ-026 Deassertion SHALL be sampled synchronously; first active edge behaves per mode/en inputs.
REQ-027 Reset mid-scan SHALL restart the scan at index 0 with a full tick period.

Configuration
REQ-028 Macro DEC_SCAN_ACTIVE_LOW_EN defined: out SHALL be inverted (one-cold, inactive = all ones, incl. reset and en=0) for common-anode digit drive.
REQ-029 Macro undefined: out one-hot active-high, inactive = all zeros; idx and wrap unaffected either way.

Structure
REQ-030 Package dec_scan_pkg SHALL hold mode constants (MODE_DIRECT=0, MODE_SCAN=1) and the OUT_W derivation function.
REQ-031 Prescaler SHALL be a separate sub-module dec_tick_gen (inputs clk, rst_n, clr, div; output tick).
REQ-032 Decode of idx to out SHALL be the only combinational path before the out register.

Verification (IN_W=3, macro undefined unless noted)
REQ-033 Direct: en=1, mode=0, in=0..7 sequentially -> out one cycle later = 8'b0000_0001..8'b1000_0000, idx=in.
REQ-034 Enable: en=0 with in=5 -> out=8'h00 next edge, idx holds previous value; en=1 -> out=8'h20.
REQ-035 Scan: mode=1, in=3, div=2 -> idx 0,1,2,3,0 each held 3 cycles; wrap one cycle at the 3->0 edge; out=01,02,04,08,01.
REQ-036 Boundary: scan at idx=6, in changed to 2 -> next tick idx=0 with wrap; div=0, in=7 -> idx steps every cycle 0..7, wrap every 8 cycles.
REQ-037 Reset mid-scan at idx=5 -> out=00, idx=0, wrap=0 immediately (asynchronous); after release scan resumes at 0 with full period.
REQ-038 DEC_SCAN_ACTIVE_LOW_EN defined: direct in=2 -> out=8'b1111_1011; reset and en=0 -> out=8'hFF.
